duty_cycle_fsm: RTL
===================

// Module: duty_cycle_fsm
// PURPOSE
//   Parametrised successor of the single-instance sleeping/working/resting state machine.
//   - Runs N_CH independent copies of that FSM.
//   - Adds a per-channel work-time limit, a programmable rest period and a cap on
//     concurrently working channels, enforced by round-robin start arbitration.
//   - Sits between per-channel request logic and a shared resource pool.
// PARAMETERS
//   N_CH        4    number of channels (>=1)
//   CNT_W       8    width of work/rest counters and rest_len_i
//   WORK_MAX    100  max cycles a channel may stay WORKING (1..2**CNT_W-1)
//   MAX_ACTIVE  2    max channels WORKING at once (1..N_CH)
// PORTS
//   clk          in   1                   clock, all state on rising edge
//   rst_n        in   1                   asynchronous reset, active-low
//   start_i      in   N_CH                per-channel start request, level
//   done_i       in   N_CH                per-channel work complete
//   abort_i      in   N_CH                per-channel abort
//   rest_len_i   in   CNT_W               rest length, sampled on entry to RESTING
//   state_o      out  2*N_CH              ch i state at [2i+1:2i]
//   grant_o      out  N_CH                one-hot pulse, channel entered WORKING
//   timeout_o    out  N_CH                pulse, WORKING exited by WORK_MAX limit
//   active_cnt_o out  $clog2(N_CH+1)      number of channels currently WORKING
//   busy_o       out  1                   any channel not SLEEPING
// BEHAVIOUR
//   Reset: all channels SLEEPING; counters, rr pointer and all outputs 0.
//     Reset is asynchronous and active-low; asserting it mid-operation aborts every
//     channel immediately, with no pulses.
//   State encoding: SLEEPING=2'b00, WORKING=2'b01, RESTING=2'b10; 2'b11 recovers to SLEEPING.
//   Transitions (registered, 1-cycle latency from input to state_o):
//     SLEEPING->WORKING  start_i[i]=1 and channel i is granted.
//     WORKING->RESTING   done_i[i]=1, or work_cnt==WORK_MAX-1 (also pulses timeout_o[i]).
//     RESTING->SLEEPING  rest_cnt==0.
//     WORKING->SLEEPING  abort_i[i]=1; rest period is skipped.
//   Priority in WORKING: abort > done > timeout. done and timeout in the same cycle give
//     RESTING with no timeout pulse.
//   Inputs are ignored in states where they are not listed.
//   Counters:
//     work_cnt clears on WORKING entry and increments each WORKING cycle.
//     rest_cnt loads rest_len_i on RESTING entry and decrements to 0.
//     RESTING therefore lasts rest_len_i+1 cycles; rest_len_i=0 gives 1 cycle.
//   Arbitration:
//     At most one grant per cycle, and only if active_cnt_o < MAX_ACTIVE.
//     Candidates are SLEEPING channels with start_i=1, chosen round-robin starting at ptr.
//     After a grant, ptr = granted index+1, wrapping at N_CH. With no grant, ptr holds.
//     A slot freed by a channel leaving WORKING becomes available the following cycle,
//       because active_cnt_o is registered.
//   grant_o and timeout_o: single-cycle pulses aligned with the state_o change.
//     They are 0 when no event occurs.
//   active_cnt_o: registered; equals the count of WORKING channels in state_o every cycle.
//   busy_o: combinational OR over non-SLEEPING channels.
// STRUCTURE
//   Package duty_cycle_pkg: state_e typedef (SLEEPING/WORKING/RESTING) and
//     encoding constants.
//   Sub-module rr_arbiter #(N): req, enable -> one-hot gnt, internal pointer.
//   Per-channel FSM and counters in a generate loop inside duty_cycle_fsm.
// TESTING
//   1. Single channel, N_CH=4, rest_len_i=3: start_i[0] for 1 cycle, done_i[0] 5 cycles later.
//      Required: grant_o=0001; then RESTING for 4 cycles; then SLEEPING; timeout_o stays 0.
//   2. Timeout, WORK_MAX=100: hold ch1 WORKING with no done_i.
//      Required: exits after 100 cycles, timeout_o[1] pulses once, ch1 goes to RESTING.
//   3. Concurrency cap, MAX_ACTIVE=2: all four start_i high from reset.
//      Required: grants 0001 then 0010; active_cnt_o=2; ch2/ch3 wait until ch0 finishes,
//      then ch2 is granted one cycle after the slot frees.
//   4. Fairness: start_i=1111 held, WORK_MAX=4, rest_len_i=0, MAX_ACTIVE=1.
//      Required: grant order 0,1,2,3,0,... with no channel skipped.
//   5. Priority: ch0 WORKING; abort_i, done_i and the timeout cycle all coincide.
//      Required: SLEEPING, no timeout pulse. Separately, done_i with timeout gives
//      RESTING and timeout_o=0.
//   6. Reset mid-operation: assert rst_n=0 with 2 channels WORKING and 1 RESTING.
//      Required: state_o=0, active_cnt_o=0, busy_o=0 without waiting for clk; after
//      release, the first grant goes to ch0.

Source files
------------

// File: rtl/duty_cycle_pkg.sv
// Shared state encoding and sizing helpers for the duty-cycle channel FSMs.
package duty_cycle_pkg;

  typedef enum logic [1:0] {
    SLEEPING = 2'b00,
    WORKING  = 2'b01,
    RESTING  = 2'b10
  } state_e;

  localparam logic [1:0] ST_SLEEPING = 2'b00;
  localparam logic [1:0] ST_WORKING  = 2'b01;
  localparam logic [1:0] ST_RESTING  = 2'b10;

  // Width needed to hold a count of 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter; search starts at ptr, ptr moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            idx;

  // Walk offsets high-to-low so the lowest offset from ptr wins last.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = 0;
    if (en_i) begin
      for (int off = N - 1; off >= 0; off--) begin
        idx = int'(ptr_q) + off;
        if (idx >= N) idx = idx - N;
        if (req_i[idx]) begin
          gnt_o      = '0;
          gnt_o[idx] = 1'b1;
          ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/duty_cycle_fsm.sv
// N_CH sleeping/working/resting channels with work-time limit, rest period and
// a round-robin-enforced cap on concurrently working channels.
module duty_cycle_fsm
  import duty_cycle_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int WORK_MAX   = 100,
  parameter int MAX_ACTIVE = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CH-1:0]                start_i,
  input  logic [N_CH-1:0]                done_i,
  input  logic [N_CH-1:0]                abort_i,
  input  logic [CNT_W-1:0]               rest_len_i,
  output logic [2*N_CH-1:0]              state_o,
  output logic [N_CH-1:0]                grant_o,
  output logic [N_CH-1:0]                timeout_o,
  output logic [cnt_width(N_CH)-1:0]     active_cnt_o,
  output logic                           busy_o
);

  localparam int                CW        = cnt_width(N_CH);
  localparam logic [CNT_W-1:0]  WORK_LAST = CNT_W'(WORK_MAX - 1);

  logic [N_CH-1:0] req, gnt;
  logic [N_CH-1:0] work_d, awake;
  logic [N_CH-1:0] grant_q, timeout_q, timeout_d;
  logic [CW-1:0]   act_q, act_d;
  logic            arb_en;

  // active count is registered, so a freed slot is only visible a cycle later
  assign arb_en = (act_q < CW'(MAX_ACTIVE));

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           st_q, st_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    assign req[i] = start_i[i] && (st_q == SLEEPING);

    always_comb begin
      st_d         = st_q;
      wcnt_d       = wcnt_q;
      rcnt_d       = rcnt_q;
      timeout_d[i] = 1'b0;
      case (st_q)
        SLEEPING: begin
          if (gnt[i]) begin
            st_d   = WORKING;
            wcnt_d = '0;
          end
        end
        WORKING: begin
          // abort > done > timeout; timeout pulses only when it alone ends work
          if (abort_i[i]) begin
            st_d = SLEEPING;
          end else if (done_i[i]) begin
            st_d   = RESTING;
            rcnt_d = rest_len_i;
          end else if (wcnt_q == WORK_LAST) begin
            st_d         = RESTING;
            rcnt_d       = rest_len_i;
            timeout_d[i] = 1'b1;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
        RESTING: begin
          if (rcnt_q == '0) st_d = SLEEPING;
          else              rcnt_d = rcnt_q - CNT_W'(1);
        end
        default: st_d = SLEEPING;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= SLEEPING;
        wcnt_q <= '0;
        rcnt_q <= '0;
      end else begin
        st_q   <= st_d;
        wcnt_q <= wcnt_d;
        rcnt_q <= rcnt_d;
      end
    end

    assign work_d[i]          = (st_d == WORKING);
    assign awake[i]           = (st_q != SLEEPING);
    assign state_o[2*i +: 2]  = st_q;
  end

  always_comb begin
    act_d = '0;
    for (int i = 0; i < N_CH; i++) act_d = act_d + CW'(work_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      timeout_q <= '0;
      act_q     <= '0;
    end else begin
      grant_q   <= gnt;
      timeout_q <= timeout_d;
      act_q     <= act_d;
    end
  end

  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;
  assign active_cnt_o = act_q;
  assign busy_o       = |awake;

endmodule
